regfile_arbiter: RTL and testbench

Shares the 8x16 register file between two requesters, M0 (CPU datapath) and M1 (debug/host port). Each requester gets a dedicated read port (M0 on SR1, M1 on SR2). The single write port is arbitrated round-robin. A built-in scrub sequencer zeroes R0..R7 on command. The block sits between the requesters and the register file and is the only driver of the register file's address, data and load inputs.

---
 rtl/regfile_arbiter.sv | 141 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-requester front end for the 8x16 register file: dedicated read ports,
// a round-robin write port and a scrub sequencer. Optional RF_ARB_FWD_EN forwarding.
module regfile_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [2:0]  m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [2:0]  m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,
  input  logic        clr_req,
  output logic        clr_done,
  output logic        rf_ld,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_data,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  input  logic [15:0] rf_sr1_q,
  input  logic [15:0] rf_sr2_q
);
  localparam int NUM_PORTS = 2;

  typedef enum logic {IDLE, SCRUB} state_t;
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } req_t;

  state_t state, state_nxt;
  logic   rr, rr_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic   idle;

  req_t [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0]            rd_acc, wr_req, wr_gnt, rvalid_q;
  logic [NUM_PORTS-1:0][2:0]       sr, sr_q;
  logic [NUM_PORTS-1:0][15:0]      rf_q, rq;

  assign req[0] = {m0_valid, m0_we, m0_addr, m0_wdata};
  assign req[1] = {m1_valid, m1_we, m1_addr, m1_wdata};
  assign rf_q   = {rf_sr2_q, rf_sr1_q};
  assign idle   = (state == IDLE) && !Reset;

  // Port 0 wins on rr=0, port 1 on rr=1; only contention consults rr.
  assign wr_gnt = (&wr_req) ? (rr ? 2'b10 : 2'b01) : wr_req;

`ifdef RF_ARB_FWD_EN
  logic [NUM_PORTS-1:0] fwd_q;
  logic [15:0]          fwd_data_q;

  always_ff @(posedge Clk) fwd_data_q <= rf_data;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign rd_acc[p] = idle && req[p].valid && !req[p].we;
    assign wr_req[p] = idle && req[p].valid && req[p].we;
    // Read index follows the request while reading, otherwise holds.
    assign sr[p]     = rd_acc[p] ? req[p].addr : sr_q[p];

    always_ff @(posedge Clk) begin
      if (Reset) begin
        sr_q[p]     <= '0;
        rvalid_q[p] <= 1'b0;
      end else begin
        sr_q[p]     <= sr[p];
        rvalid_q[p] <= rd_acc[p];
      end
    end

`ifdef RF_ARB_FWD_EN
    always_ff @(posedge Clk) begin
      if (Reset) fwd_q[p] <= 1'b0;
      else       fwd_q[p] <= rd_acc[p] && wr_gnt[1-p] && (req[p].addr == req[1-p].addr);
    end
    assign rq[p] = fwd_q[p] ? fwd_data_q : rf_q[p];
`else
    assign rq[p] = rf_q[p];
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    rf_ld     = 1'b0;
    rf_dr     = '0;
    rf_data   = '0;
    clr_done  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_gnt[0]) begin
          rf_ld = 1'b1; rf_dr = req[0].addr; rf_data = req[0].wdata;
        end else if (wr_gnt[1]) begin
          rf_ld = 1'b1; rf_dr = req[1].addr; rf_data = req[1].wdata;
        end
        if (&wr_req) rr_nxt = ~rr;
        if (clr_req) state_nxt = SCRUB;
      end
      SCRUB: begin
        rf_ld    = !Reset;
        rf_dr    = cnt;
        clr_done = !Reset && (cnt == 3'd7);
        cnt_nxt  = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_ready  = rd_acc[0] | wr_gnt[0];
  assign m1_ready  = rd_acc[1] | wr_gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rq[0];
  assign m1_rdata  = rq[1];
  assign rf_sr1    = sr[0];
  assign rf_sr2    = sr[1];
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the shared register file.
module tb_regfile_arbiter;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic        m0_valid = 0, m0_we = 0, m1_valid = 0, m1_we = 0, clr_req = 0;
  logic [2:0]  m0_addr = 0, m1_addr = 0;
  logic [15:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid, clr_done, rf_ld;
  logic [15:0] m0_rdata, m1_rdata, rf_data, rf_sr1_q, rf_sr2_q;
  logic [2:0]  rf_dr, rf_sr1, rf_sr2;

`ifdef RF_ARB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  regfile_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clr_req(clr_req), .clr_done(clr_done),
    .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_data(rf_data),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_sr1_q(rf_sr1_q), .rf_sr2_q(rf_sr2_q)
  );

  always #5 Clk = ~Clk;

  // Register file environment: registered read outputs, write on rf_ld.
  logic [15:0] rf_mem [8];
  always @(posedge Clk) begin
    if (rf_ld) rf_mem[rf_dr] <= rf_data;
    rf_sr1_q <= rf_mem[rf_sr1];
    rf_sr2_q <= rf_mem[rf_sr2];
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: register contents, arbitration priority, scrub progress,
  // and the read result owed to each port in the next cycle.
  logic [15:0] mem [8];
  bit          rr = 0, scrub = 0;
  int          scnt = 0;
  logic [1:0]  ev = '0;
  logic [15:0] erd [2];

  task automatic step();
    logic [1:0]  rd, wr, g;
    logic        eld, edone;
    logic [2:0]  edr;
    logic [15:0] edata;
    logic [15:0] nmem [8];
    #1;
    rd = '0; wr = '0; g = '0; eld = 0; edone = 0; edr = '0; edata = '0;
    nmem = mem;
    if (Reset) begin
    end else if (scrub) begin
      eld = 1; edr = 3'(scnt); edone = (scnt == 7);
    end else begin
      rd = {m1_valid & ~m1_we, m0_valid & ~m0_we};
      wr = {m1_valid & m1_we, m0_valid & m0_we};
      g  = (wr == 2'b11) ? (rr ? 2'b10 : 2'b01) : wr;
      if (g[0]) begin eld = 1; edr = m0_addr; edata = m0_wdata; end
      if (g[1]) begin eld = 1; edr = m1_addr; edata = m1_wdata; end
    end
    if (eld) nmem[edr] = edata;

    chk("ready", {30'd0, m1_ready, m0_ready}, {30'd0, rd | g});
    chk("rf_ld", {31'd0, rf_ld}, {31'd0, eld});
    if (eld) chk("rf_wr", {13'd0, rf_dr, rf_data}, {13'd0, edr, edata});
    chk("clr_done", {31'd0, clr_done}, {31'd0, edone});
    if (rd[0]) chk("rf_sr1", {29'd0, rf_sr1}, {29'd0, m0_addr});
    if (rd[1]) chk("rf_sr2", {29'd0, rf_sr2}, {29'd0, m1_addr});
    chk("rvalid", {30'd0, m1_rvalid, m0_rvalid}, {30'd0, ev});
    if (ev[0]) chk("m0_rdata", {16'd0, m0_rdata}, {16'd0, erd[0]});
    if (ev[1]) chk("m1_rdata", {16'd0, m1_rdata}, {16'd0, erd[1]});

    @(posedge Clk);
    if (Reset) begin
      rr = 0; scrub = 0; scnt = 0; ev = '0;
    end else if (scrub) begin
      ev = '0;
      if (scnt == 7) begin scrub = 0; scnt = 0; end
      else scnt++;
    end else begin
      ev = rd;
      erd[0] = FWD ? nmem[m0_addr] : mem[m0_addr];
      erd[1] = FWD ? nmem[m1_addr] : mem[m1_addr];
      if (wr == 2'b11) rr = ~rr;
      scrub = clr_req;
    end
    mem = nmem;
    #1;
  endtask

  task automatic drv(input bit v0, input bit w0, input int a0, input int d0,
                     input bit v1, input bit w1, input int a1, input int d1,
                     input bit clr = 0, input bit rst = 0);
    m0_valid = v0; m0_we = w0; m0_addr = 3'(a0); m0_wdata = 16'(d0);
    m1_valid = v1; m1_we = w1; m1_addr = 3'(a1); m1_wdata = 16'(d1);
    clr_req = clr; Reset = rst;
    step();
  endtask

  task automatic rnd_drv(input bit clr = 0, input bit rst = 0);
    drv($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
        $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom, clr, rst);
  endtask

  initial begin
    Reset = 1;
    @(posedge Clk); #1;
    drv(1, 1, 1, 'h1111, 1, 0, 2, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    // Contention with rr=0, then M1 alone, then contention won by M1
    drv(1, 1, 1, 'hAAAA, 1, 1, 2, 'h5555);
    drv(0, 0, 0, 0, 1, 1, 2, 'h5555);
    drv(1, 1, 5, 'h0505, 1, 1, 6, 'h0606);
    drv(1, 1, 5, 'h0505, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drv(1, 1, i, 'h1000 + i * 'h111, 0, 0, 0, 0);
    drv(1, 1, 3, 'h1234, 0, 0, 0, 0);
    drv(1, 0, 3, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 1, 4, 'h0BAD);
    drv(1, 0, 4, 0, 1, 1, 4, 'hBEEF);
    drv(1, 0, 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drv(0, 0, 0, 0, 1, 0, i, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    // Full scrub with requests pending throughout
    for (int i = 0; i < 8; i++) drv(0, 1, i, 'hF0F0 ^ i, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drv(1, 0, i, 0, 1, 1, i, 'hFFFF, 1);
    for (int i = 0; i < 8; i++) drv(1, 0, i, 0, 1, 0, 7 - i, 0);
    // Reset during the 4th scrub cycle
    for (int i = 0; i < 8; i++) drv(1, 1, i, 'h0A00 + i, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 1, 1, 1, 'h7777, 0, 1);
    drv(1, 1, 2, 'h2222, 1, 0, 6, 0);
    for (int i = 0; i < 8; i++) drv(1, 0, i, 0, 1, 0, i, 0);
    for (int i = 0; i < 2000; i++)
      rnd_drv($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
